hsv_core_alu_exec: RTL and testbench
====================================

HSV_CORE_ALU_EXEC -- requirements
Module: hsv_core_alu_exec

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: operand/result width; only 32 is supported.
REQ-002 The block SHALL have port clk_core  in  1  core clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_core  in  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port flush  in  1  discard all in-flight operations.
REQ-005 The block SHALL have port in_valid  in  1  upstream offers an operation.
REQ-006 The block SHALL have port in_ready  out  1  block accepts the offered operation this cycle.
REQ-007 The block SHALL have port alu_data  in  alu_data_t  decoded controls: negate, flip_signs, bitwise_select, sign_extend, is_immediate, compare, out_select, pc_relative, illegal, common.
REQ-008 The block SHALL have port rs1_value  in  XLEN  operand A; the issue stage supplies 0 for LUI.
REQ-009 The block SHALL have port rs2_value  in  XLEN  operand B.
REQ-010 The block SHALL have port immediate  in  XLEN  sign-extended immediate.
REQ-011 The block SHALL have port pc  in  XLEN  instruction address.
REQ-012 The block SHALL have port out_valid  out  1  result available.
REQ-013 The block SHALL have port out_ready  in  1  downstream consumes the result.
REQ-014 The block SHALL have port out_result  out  XLEN  computed value.
REQ-015 The block SHALL have port out_common  out  exec_mem_common_t  alu_data.common carried unchanged.
REQ-016 The block SHALL have port out_illegal  out  1  alu_data.illegal carried unchanged.

Function
REQ-017 A transfer SHALL occur on a cycle with in_valid && in_ready; the output handshake SHALL complete on a cycle with out_valid && out_ready.
REQ-018 Operand selection SHALL be: a = pc_relative ? pc : rs1_value; b = is_immediate ? immediate : rs2_value.
REQ-019 Stage 1 SHALL register the adder sum a + (negate ? ~b : b) + negate, mod 2^32, together with the carry-out.
REQ-020 When flip_signs=1, stage 1 SHALL invert bit 31 of a and b before the adder.
REQ-021 Stage 1 SHALL register the bitwise value a&b, a|b, a^b or a, selected by bitwise_select AND, OR, XOR or PASS.
REQ-022 Stage 1 SHALL register the shift amount b[4:0] for PASS and 0 otherwise.
REQ-023 Stage 2 SHALL compute the shifter on the bitwise value: left shift if negate, else right shift, filling with bit 31 if sign_extend and with 0 otherwise.
REQ-024 When compare=1, the adder result SHALL be {31'b0, ~carry_out}, i.e. 1 iff a < b for the selected signedness.
REQ-025 out_result SHALL be the shifter output when out_select=ALU_OUT_SHIFT and the adder result otherwise.
REQ-026 Latency SHALL be exactly 2 cycles from the input transfer to out_valid when unstalled.
REQ-027 Throughput SHALL be 1 operation per cycle.
REQ-028 Stage 2 SHALL hold its contents while out_valid && !out_ready.
REQ-029 Stage 1 SHALL advance when stage 2 is empty or is completing its handshake.
REQ-030 in_ready SHALL equal !s1_valid || s1_advance, combinationally.
REQ-031 Operands SHALL be registered only on a transfer, and out_result and out_common SHALL remain stable while stalled.
REQ-032 flush SHALL clear both stage valids on the next edge.
REQ-033 An operation presented on the same cycle as flush SHALL be dropped.
REQ-034 flush SHALL take priority over every handshake.
REQ-035 Illegal operations SHALL flow through with out_illegal=1; out_result is don't-care for them.
REQ-036 When both stages are full and out_ready=1, a new operation SHALL be accepted in the same cycle with no bubble.

Reset
REQ-037 While rst_core=1, the stage valids SHALL clear, out_valid=0 and in_ready=1 on the next edge.
REQ-038 A reset asserted mid-operation SHALL discard all in-flight operations.
REQ-039 Datapath registers SHALL need no reset; out_result=0 and out_illegal=0 SHALL hold out of reset until the first result.

Verification
REQ-040 The bench SHALL cover: ADD rs1=0xFFFFFFFF, rs2=1 -> out_result=0x00000000 exactly 2 cycles after acceptance.
REQ-041 The bench SHALL cover: SLT rs1=0xFFFFFFFF, rs2=1 -> 1; SLTU with the same operands -> 0.
REQ-042 The bench SHALL cover: SRAI rs1=0x80000000, imm=4 -> 0xF8000000; SLL rs1=1, rs2=31 -> 0x80000000; XORI rs1=0xF0F0F0F0, imm=0xFFFFFFFF -> 0x0F0F0F0F.
REQ-043 The bench SHALL cover: AUIPC pc=0x1000, imm=0x2000 -> 0x3000; LUI imm=0xABCDE000 with rs1=0 -> 0xABCDE000.
REQ-044 The bench SHALL cover: back-to-back stream of 8 ops with out_ready low for 3 cycles mid-stream -> in_ready drops after 2 further accepts, and results arrive in order with no loss or duplication.
REQ-045 The bench SHALL cover: flush with both stages full plus a new in_valid -> out_valid=0 next cycle, and none of the 3 ops ever appear; reset mid-stream behaves identically.

Source files
------------

// File: rtl/hsv_core_alu_exec.sv
// Two-stage integer ALU: stage 1 forms operands, adder and bitwise value;
// stage 2 applies the shifter/compare fix-up and holds the result for the consumer.
package hsv_core_alu_pkg;
    typedef enum logic [1:0] {
        ALU_BITWISE_AND,
        ALU_BITWISE_OR,
        ALU_BITWISE_XOR,
        ALU_BITWISE_PASS
    } alu_bitwise_select_t;

    typedef enum logic {
        ALU_OUT_ADDER,
        ALU_OUT_SHIFT
    } alu_out_select_t;

    typedef struct packed {
        logic [31:0] token;
        logic [4:0]  rd_addr;
    } exec_mem_common_t;

    typedef struct packed {
        logic                negate;
        logic                flip_signs;
        alu_bitwise_select_t bitwise_select;
        logic                sign_extend;
        logic                is_immediate;
        logic                compare;
        alu_out_select_t     out_select;
        logic                pc_relative;
        logic                illegal;
        exec_mem_common_t    common;
    } alu_data_t;
endpackage

module hsv_core_alu_exec
    import hsv_core_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk_core,
    input  logic             rst_core,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_data_t        alu_data,
    input  logic [XLEN-1:0]  rs1_value,
    input  logic [XLEN-1:0]  rs2_value,
    input  logic [XLEN-1:0]  immediate,
    input  logic [XLEN-1:0]  pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output exec_mem_common_t out_common,
    output logic             out_illegal
);
    logic                s1_valid_q, s1_valid_d;
    logic                s2_valid_q, s2_valid_d;
    logic                s1_advance, transfer;

    logic [XLEN-1:0]     s1_sum_q, s1_sum_d;
    logic                s1_carry_q, s1_carry_d;
    logic [XLEN-1:0]     s1_bitwise_q, s1_bitwise_d;
    logic [4:0]          s1_shamt_q, s1_shamt_d;
    logic                s1_negate_q, s1_sign_extend_q, s1_compare_q, s1_illegal_q;
    alu_out_select_t     s1_out_select_q;
    exec_mem_common_t    s1_common_q;

    logic [XLEN-1:0]     s2_result_q, s2_result_d;
    logic                s2_illegal_q;
    exec_mem_common_t    s2_common_q;

    logic [XLEN-1:0]     op_a, op_b, add_a, add_b;
    logic [XLEN-1:0]     shift_res, adder_res;

    // Stage 1 drains when stage 2 is empty or handing its result off this cycle.
    assign s1_advance = !s2_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s1_advance;
    assign transfer   = in_valid && in_ready && !flush;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (rst_core || flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (in_ready)   s1_valid_d = in_valid;
            if (s1_advance) s2_valid_d = s1_valid_q;
        end
    end

    always_comb begin
        op_a  = alu_data.pc_relative  ? pc        : rs1_value;
        op_b  = alu_data.is_immediate ? immediate : rs2_value;
        add_a = op_a;
        add_b = op_b;
        // Biasing the sign bits turns the unsigned borrow into a signed compare.
        if (alu_data.flip_signs) begin
            add_a[XLEN-1] = ~op_a[XLEN-1];
            add_b[XLEN-1] = ~op_b[XLEN-1];
        end
        if (alu_data.negate) add_b = ~add_b;
        {s1_carry_d, s1_sum_d} = {1'b0, add_a} + {1'b0, add_b}
                               + {{XLEN{1'b0}}, alu_data.negate};
        unique case (alu_data.bitwise_select)
            ALU_BITWISE_AND: s1_bitwise_d = op_a & op_b;
            ALU_BITWISE_OR:  s1_bitwise_d = op_a | op_b;
            ALU_BITWISE_XOR: s1_bitwise_d = op_a ^ op_b;
            default:         s1_bitwise_d = op_a;
        endcase
        s1_shamt_d = (alu_data.bitwise_select == ALU_BITWISE_PASS) ? op_b[4:0] : 5'd0;
    end

    always_comb begin
        if (s1_negate_q)
            shift_res = s1_bitwise_q << s1_shamt_q;
        else if (s1_sign_extend_q)
            shift_res = XLEN'($signed(s1_bitwise_q) >>> s1_shamt_q);
        else
            shift_res = s1_bitwise_q >> s1_shamt_q;
        adder_res   = s1_compare_q ? {{(XLEN-1){1'b0}}, ~s1_carry_q} : s1_sum_q;
        s2_result_d = (s1_out_select_q == ALU_OUT_SHIFT) ? shift_res : adder_res;
    end

    always_ff @(posedge clk_core) begin
        s1_valid_q <= s1_valid_d;
        s2_valid_q <= s2_valid_d;
    end

    always_ff @(posedge clk_core) begin
        if (transfer) begin
            s1_sum_q         <= s1_sum_d;
            s1_carry_q       <= s1_carry_d;
            s1_bitwise_q     <= s1_bitwise_d;
            s1_shamt_q       <= s1_shamt_d;
            s1_negate_q      <= alu_data.negate;
            s1_sign_extend_q <= alu_data.sign_extend;
            s1_compare_q     <= alu_data.compare;
            s1_out_select_q  <= alu_data.out_select;
            s1_illegal_q     <= alu_data.illegal;
            s1_common_q      <= alu_data.common;
        end
    end

    // Result and illegal flag are reset so the outputs read 0 before the first result.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            s2_result_q  <= '0;
            s2_illegal_q <= 1'b0;
        end else if (s1_valid_q && s1_advance && !flush) begin
            s2_result_q  <= s2_result_d;
            s2_illegal_q <= s1_illegal_q;
            s2_common_q  <= s1_common_q;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_result  = s2_result_q;
    assign out_common  = s2_common_q;
    assign out_illegal = s2_illegal_q;
endmodule

// File: tb/tb_hsv_core_alu_exec.sv
// Directed bench for hsv_core_alu_exec: op vectors, stall stream, flush and reset drops.
module tb_hsv_core_alu_exec;
    import hsv_core_alu_pkg::*;

    logic             clk_core = 1'b0;
    logic             rst_core, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    alu_data_t        alu_data;
    logic [31:0]      rs1_value, rs2_value, immediate, pc, out_result;
    exec_mem_common_t out_common;

    int n_cmp = 0;
    int n_err = 0;

    hsv_core_alu_exec #(.XLEN(32)) dut (
        .clk_core(clk_core), .rst_core(rst_core), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .alu_data(alu_data),
        .rs1_value(rs1_value), .rs2_value(rs2_value), .immediate(immediate), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_common(out_common), .out_illegal(out_illegal)
    );

    always #5 clk_core = ~clk_core;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic alu_data_t mk(input bit neg, input bit flip, input alu_bitwise_select_t bsel,
                                     input bit sext, input bit imm, input bit cmp,
                                     input alu_out_select_t osel, input bit pcrel, input bit ill,
                                     input logic [31:0] tok);
        alu_data_t d;
        d.negate = neg;        d.flip_signs = flip;   d.bitwise_select = bsel;
        d.sign_extend = sext;  d.is_immediate = imm;  d.compare = cmp;
        d.out_select = osel;   d.pc_relative = pcrel; d.illegal = ill;
        d.common.token = tok;  d.common.rd_addr = tok[4:0];
        return d;
    endfunction

    task automatic drive(input alu_data_t d, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] im, input logic [31:0] p);
        alu_data = d; rs1_value = r1; rs2_value = r2; immediate = im; pc = p;
    endtask

    // One isolated op: accepted on the first edge, visible two cycles later.
    task automatic run_op(input string tag, input alu_data_t d, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] im, input logic [31:0] p,
                          input logic [31:0] exp);
        @(negedge clk_core);
        drive(d, r1, r2, im, p);
        in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk_core);
        in_valid = 1'b0;
        #1 chk({tag, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk_core);
        #1 chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        if (!d.illegal) chk(tag, out_result, exp);
        chk({tag, "_ill"}, 32'(out_illegal), 32'(d.illegal));
        chk({tag, "_tok"}, out_common.token, d.common.token);
    endtask

    alu_data_t ADD, SUB, SLT, SLTU, SRAI, SRLI, SLL, XORI, AND, AUIPC, LUI, ILL;
    bit exp_rdy[11] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    int exp_oc[8]   = '{2, 6, 7, 8, 9, 10, 11, 12};

    initial begin
        int sent, rcv, seen;
        ADD   = mk(0, 0, ALU_BITWISE_PASS, 0, 0, 0, ALU_OUT_ADDER, 0, 0, 32'h11);
        SUB   = mk(1, 0, ALU_BITWISE_PASS, 0, 0, 0, ALU_OUT_ADDER, 0, 0, 32'h12);
        SLT   = mk(1, 1, ALU_BITWISE_PASS, 0, 0, 1, ALU_OUT_ADDER, 0, 0, 32'h13);
        SLTU  = mk(1, 0, ALU_BITWISE_PASS, 0, 0, 1, ALU_OUT_ADDER, 0, 0, 32'h14);
        SRAI  = mk(0, 0, ALU_BITWISE_PASS, 1, 1, 0, ALU_OUT_SHIFT, 0, 0, 32'h15);
        SRLI  = mk(0, 0, ALU_BITWISE_PASS, 0, 1, 0, ALU_OUT_SHIFT, 0, 0, 32'h16);
        SLL   = mk(1, 0, ALU_BITWISE_PASS, 0, 0, 0, ALU_OUT_SHIFT, 0, 0, 32'h17);
        XORI  = mk(0, 0, ALU_BITWISE_XOR,  0, 1, 0, ALU_OUT_SHIFT, 0, 0, 32'h18);
        AND   = mk(0, 0, ALU_BITWISE_AND,  0, 0, 0, ALU_OUT_SHIFT, 0, 0, 32'h19);
        AUIPC = mk(0, 0, ALU_BITWISE_PASS, 0, 1, 0, ALU_OUT_ADDER, 1, 0, 32'h1A);
        LUI   = mk(0, 0, ALU_BITWISE_PASS, 0, 1, 0, ALU_OUT_ADDER, 0, 0, 32'h1B);
        ILL   = mk(0, 0, ALU_BITWISE_PASS, 0, 0, 0, ALU_OUT_ADDER, 0, 1, 32'h1C);

        rst_core = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(ADD, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk_core);
        #1 chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        chk("rst_res", out_result, 32'h0);
        chk("rst_ill", 32'(out_illegal), 32'd0);
        @(negedge clk_core);
        rst_core = 1'b0;
        @(negedge clk_core);
        #1 chk("post_rst_res", out_result, 32'h0);
        chk("post_rst_vld", 32'(out_valid), 32'd0);

        run_op("add_wrap", ADD,   32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,    32'h0000_0000);
        run_op("sub",      SUB,   32'h5,         32'h7,         32'h0,         32'h0,    32'hFFFF_FFFE);
        run_op("slt",      SLT,   32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,    32'h1);
        run_op("slt_pos",  SLT,   32'h1,         32'hFFFF_FFFF, 32'h0,         32'h0,    32'h0);
        run_op("sltu",     SLTU,  32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,    32'h0);
        run_op("srai",     SRAI,  32'h8000_0000, 32'h0,         32'h4,         32'h0,    32'hF800_0000);
        run_op("srli",     SRLI,  32'h8000_0000, 32'h0,         32'h4,         32'h0,    32'h0800_0000);
        run_op("sll",      SLL,   32'h1,         32'd31,        32'h0,         32'h0,    32'h8000_0000);
        run_op("xori",     XORI,  32'hF0F0_F0F0, 32'h0,         32'hFFFF_FFFF, 32'h0,    32'h0F0F_0F0F);
        run_op("and",      AND,   32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0,         32'h0,    32'h0F00_0F00);
        run_op("auipc",    AUIPC, 32'h5555_5555, 32'h0,         32'h2000,      32'h1000, 32'h3000);
        run_op("lui",      LUI,   32'h0,         32'h0,         32'hABCD_E000, 32'h0,    32'hABCD_E000);
        run_op("illegal",  ILL,   32'h0,         32'h0,         32'h0,         32'h0,    32'h0);

        // 8-op stream, consumer stalls in cycles 3..5.
        sent = 0; rcv = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_core);
            in_valid = (sent < 8);
            drive(mk(0, 0, ALU_BITWISE_PASS, 0, 0, 0, ALU_OUT_ADDER, 0, 0, 32'h100 + 32'(sent)),
                  32'(sent) * 32'h11, 32'h100, 32'h0, 32'h0);
            out_ready = !(c >= 3 && c <= 5);
            #1;
            if (c <= 10) chk("stream_rdy", 32'(in_ready), 32'(exp_rdy[c]));
            if (out_valid && !out_ready) chk("stall_hold", out_result, 32'h111);
            if (out_valid && out_ready) begin
                if (rcv < 8) begin
                    chk("stream_res", out_result, 32'h100 + 32'(rcv) * 32'h11);
                    chk("stream_tok", out_common.token, 32'h100 + 32'(rcv));
                    chk("stream_cyc", 32'(c), 32'(exp_oc[rcv]));
                end else begin
                    chk("stream_extra", out_common.token, 32'hDEAD);
                end
                rcv++;
            end
            if (in_valid && in_ready) sent++;
        end
        chk("stream_count", 32'(rcv), 32'd8);
        in_valid = 1'b0;

        // Flush with both stages full and a third op offered.
        @(negedge clk_core);
        drive(mk(0, 0, ALU_BITWISE_PASS, 0, 0, 0, ALU_OUT_ADDER, 0, 0, 32'hF1), 1, 2, 0, 0);
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk_core);
        drive(mk(0, 0, ALU_BITWISE_PASS, 0, 0, 0, ALU_OUT_ADDER, 0, 0, 32'hF2), 3, 4, 0, 0);
        @(negedge clk_core);
        drive(mk(0, 0, ALU_BITWISE_PASS, 0, 0, 0, ALU_OUT_ADDER, 0, 0, 32'hF3), 5, 6, 0, 0);
        flush = 1'b1;
        #1 chk("flush_full", 32'(out_valid), 32'd1);
        @(negedge clk_core);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1 chk("flush_vld", 32'(out_valid), 32'd0);
        chk("flush_rdy", 32'(in_ready), 32'd1);
        @(negedge clk_core);
        drive(mk(0, 0, ALU_BITWISE_PASS, 0, 0, 0, ALU_OUT_ADDER, 0, 0, 32'hF4), 7, 8, 0, 0);
        in_valid = 1'b1; flush = 1'b1;
        #1 chk("flush_empty_rdy", 32'(in_ready), 32'd1);
        @(negedge clk_core);
        in_valid = 1'b0; flush = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            #1 if (out_valid) seen++;
            @(negedge clk_core);
        end
        chk("flush_ghost", 32'(seen), 32'd0);

        // Same scenario with reset; consumer ready so the third op would be taken.
        drive(mk(0, 0, ALU_BITWISE_PASS, 0, 0, 0, ALU_OUT_ADDER, 0, 0, 32'hE1), 1, 2, 0, 0);
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk_core);
        drive(mk(0, 0, ALU_BITWISE_PASS, 0, 0, 0, ALU_OUT_ADDER, 0, 0, 32'hE2), 3, 4, 0, 0);
        @(negedge clk_core);
        drive(mk(0, 0, ALU_BITWISE_PASS, 0, 0, 0, ALU_OUT_ADDER, 0, 0, 32'hE3), 5, 6, 0, 0);
        rst_core = 1'b1;
        #1 chk("rst_mid_rdy", 32'(in_ready), 32'd1);
        @(negedge clk_core);
        rst_core = 1'b0; in_valid = 1'b0;
        #1 chk("rst_mid_vld", 32'(out_valid), 32'd0);
        chk("rst_mid_in_rdy", 32'(in_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_core);
            #1 if (out_valid) seen++;
        end
        chk("rst_ghost", 32'(seen), 32'd0);

        run_op("after_rst", ADD, 32'h1234, 32'h1, 32'h0, 32'h0, 32'h1235);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
